serial_add_ctrl: RTL and testbench
==================================

// Module: serial_add_ctrl
// PURPOSE
//   Sequencer that time-shares one 1-bit full-adder cell (instance of `adder`: A,B,Cin -> Sum,Cout)
//   to add two WIDTH-bit operands bit-serially, LSB first, one bit per clock.
//   Sits between a requester (start/done handshake) and the adder cell; owns operand shift
//   registers, carry flop, bit counter and result register. Trades area for WIDTH-cycle latency.
// PARAMETERS
//   WIDTH  8  operand/result width in bits; legal range 2..32
// PORTS
//   clk    in   1      rising-edge clock
//   rst_n  in   1      asynchronous active-low reset
//   start  in   1      request; sampled every rising edge, accepted only in IDLE or DONE
//   a      in   WIDTH  operand A; sampled only on the accepting edge
//   b      in   WIDTH  operand B; sampled only on the accepting edge
//   cin    in   1      carry-in; sampled only on the accepting edge
//   busy   out  1      1 while state==RUN
//   done   out  1      1 for exactly one cycle (state==DONE); sum/cout/ovf valid from that cycle on
//   sum    out  WIDTH  result a+b+cin, modulo 2^WIDTH
//   cout   out  1      carry out of bit WIDTH-1
//   ovf    out  1      two's-complement overflow = carry into MSB XOR carry out of MSB
// BEHAVIOUR
//   Reset (rst_n=0, asynchronous): state=IDLE; busy=0, done=0, sum=0, cout=0, ovf=0;
//     shift regs, carry flop, counter cleared. Reset mid-RUN aborts; no done pulse; old result lost.
//   FSM states IDLE, RUN, DONE (all transitions on rising clk):
//     IDLE: start=1 -> RUN; load opa<=a, opb<=b, carry<=cin, cnt<=0. start=0 -> stay.
//     RUN:  each edge: carry<=Cout, res shifts right with Sum entering MSB,
//           opa/opb shift right, cnt<=cnt+1. Cell inputs: A=opa[0], B=opb[0], Cin=carry.
//           On the edge where cnt==WIDTH-1 (final bit): sum<=final res, cout<=Cout,
//           ovf<=carry^Cout (carry here is the carry into MSB), state -> DONE.
//           start ignored in RUN (no queueing, no restart, operands unchanged).
//     DONE: done=1 for one cycle. start=1 -> RUN with fresh load (back-to-back); else -> IDLE.
//   Latency: start accepted at edge E -> done=1 in the cycle after edge E+WIDTH;
//     throughput one op per WIDTH+1 cycles when start held high.
//   busy = (state==RUN); done = (state==DONE); both decoded from registered state, glitch-free.
//   sum/cout/ovf are registered, updated only on the RUN->DONE edge, and hold across IDLE and
//     the next RUN until the next RUN->DONE edge.
//   Counter width $clog2(WIDTH); it never exceeds WIDTH-1.
//   a/b/cin changing while busy has no effect on the result.
//   Inputs X/Z while not accepting are don't-care.
// TESTING  (WIDTH=8)
//   1. a=0x00,b=0x00,cin=0, start 1 cycle -> busy 8 cycles, done pulse 1 cycle,
//      sum=0x00, cout=0, ovf=0.
//   2. a=0xFF,b=0x01,cin=0 -> sum=0x00, cout=1, ovf=0;
//      then a=0x80,b=0x80,cin=0 -> sum=0x00, cout=1, ovf=1.
//   3. a=0x7F,b=0x00,cin=1 -> sum=0x80, cout=0, ovf=1; outputs hold 0x80 for 20 idle cycles.
//   4. start held high with a=0x12,b=0x34,cin=0 then a=0x0F,b=0xF0,cin=1 on the DONE cycle
//      -> done pulses 9 cycles apart; sum=0x46 then sum=0x00, cout=1.
//   5. Pulse start with new operands 3 cycles into RUN -> ignored; first result unchanged;
//      done only once.
//   6. rst_n=0 asynchronously at bit 4 of a=0xAA+b=0x55 -> outputs 0 immediately,
//      no done, state IDLE; a new start after release completes normally with sum=0xFF.

Source files
------------

// File: rtl/serial_add_ctrl.sv
// serial_add_ctrl.sv -- bit-serial WIDTH-bit adder built around one shared 1-bit full-adder cell.
//
// Ports (serial_add_ctrl):
//   clk    in   1      rising-edge clock
//   rst_n  in   1      asynchronous active-low reset
//   start  in   1      request, accepted only in IDLE or DONE
//   a, b   in   WIDTH  operands, captured on the accepting edge
//   cin    in   1      carry-in, captured on the accepting edge
//   busy   out  1      high while the serial add is in progress
//   done   out  1      one-cycle completion pulse
//   sum    out  WIDTH  registered result a+b+cin mod 2^WIDTH
//   cout   out  1      registered carry out of the MSB
//   ovf    out  1      registered two's-complement overflow
//
// Ports (adder): A, B, Cin in; Sum, Cout out.

// Purpose: 1-bit full-adder cell shared by the serial sequencer.
// Latency: purely combinational.
// Backpressure: none; no handshake.
module adder (
  input  logic A,
  input  logic B,
  input  logic Cin,
  output logic Sum,
  output logic Cout
);
  assign Sum  = A ^ B ^ Cin;
  assign Cout = (A & B) | (Cin & (A ^ B));
endmodule

// Purpose: sequence one adder cell over WIDTH bits, LSB first, to add a+b+cin.
// Latency: start accepted at edge E -> done high in the cycle after edge E+WIDTH.
// Backpressure: start is ignored while busy; no queueing, requester must retry after done.
module serial_add_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);
  localparam int            CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next_state;

  logic [WIDTH-1:0] r_opa;
  logic [WIDTH-1:0] r_opb;
  logic [WIDTH-1:0] r_res;
  logic             r_carry;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic             r_ovf;

  logic             w_cell_sum;
  logic             w_cell_cout;
  logic             w_last;
  logic             w_accept;
  logic [WIDTH-1:0] w_res_next;

  adder u_adder (
    .A    (r_opa[0]),
    .B    (r_opb[0]),
    .Cin  (r_carry),
    .Sum  (w_cell_sum),
    .Cout (w_cell_cout)
  );

  assign w_last     = (r_cnt == LAST);
  assign w_accept   = start && ((r_state == S_IDLE) || (r_state == S_DONE));
  // Result fills from the top: after WIDTH shifts bit 0 has reached position 0.
  assign w_res_next = {w_cell_sum, r_res[WIDTH-1:1]};

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next_state = S_RUN;
      S_RUN:   if (w_last) w_next_state = S_DONE;
      S_DONE:  w_next_state = start ? S_RUN : S_IDLE;
      default: w_next_state = S_IDLE;
    endcase
  end

  // Output decode, straight from the state register so busy/done are glitch-free
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (r_state)
      S_RUN:   busy = 1'b1;
      S_DONE:  done = 1'b1;
      default: ;
    endcase
  end

  // Datapath: operand shifters, carry flop, bit counter and result registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_opa   <= '0;
      r_opb   <= '0;
      r_res   <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
      r_ovf   <= 1'b0;
    end else if (w_accept) begin
      r_opa   <= a;
      r_opb   <= b;
      r_carry <= cin;
      r_cnt   <= '0;
      r_res   <= '0;
    end else if (r_state == S_RUN) begin
      r_opa   <= r_opa >> 1;
      r_opb   <= r_opb >> 1;
      r_carry <= w_cell_cout;
      r_res   <= w_res_next;
      if (w_last) begin
        // Counter parks at 0 rather than wrapping past WIDTH-1 for non-power-of-2 widths.
        r_cnt  <= '0;
        r_sum  <= w_res_next;
        r_cout <= w_cell_cout;
        // r_carry still holds the carry into the MSB on this edge.
        r_ovf  <= r_carry ^ w_cell_cout;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  assign sum  = r_sum;
  assign cout = r_cout;
  assign ovf  = r_ovf;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Testbench for serial_add_ctrl (WIDTH=8): directed scenarios plus randomized operands,
// checked against an arithmetic reference model.
module tb_serial_add_ctrl;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
  logic         ovf;

  int vectors     = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  serial_add_ctrl #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .start (start),
    .a     (a),
    .b     (b),
    .cin   (cin),
    .busy  (busy),
    .done  (done),
    .sum   (sum),
    .cout  (cout),
    .ovf   (ovf)
  );

  // Reference: plain integer addition; overflow means the signed result leaves the W-bit range.
  function automatic void model(input logic [W-1:0] x, input logic [W-1:0] y, input logic c,
                                output logic [W-1:0] s, output logic co, output logic ov);
    int unsigned u;
    int          sx, sy, sg;
    u  = 32'(x) + 32'(y) + 32'(c);
    s  = u[W-1:0];
    co = u[W];
    sx = int'($signed(x));
    sy = int'($signed(y));
    sg = sx + sy + int'(c);
    ov = (sg > (2 ** (W - 1)) - 1) || (sg < -(2 ** (W - 1)));
  endfunction

  // Launch one operation and wait (bounded) for done. lat counts edges from the accepting
  // edge to the edge after which done is high; held reports whether sum/cout/ovf stayed put
  // while busy. Operand inputs are scrambled during RUN.
  task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tbv, input logic tc,
                        output int busy_cyc, output int lat, output bit held);
    logic [W-1:0] s0;
    logic         c0, o0;
    @(negedge clk);
    s0 = sum; c0 = cout; o0 = ovf;
    a = ta; b = tbv; cin = tc; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
    busy_cyc = 0; lat = 0; held = 1'b1;
    while (!done && lat < 40) begin
      lat++;
      if (busy) busy_cyc++;
      if (sum !== s0 || cout !== c0 || ovf !== o0) held = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic test_reset;
    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; cin = 1'b0;
    #2;
    vectors++;
    if ({busy, done, sum, cout, ovf} !== '0) begin
      miscompares++;
      $display("FAIL reset_outputs: got %h expected 0", {busy, done, sum, cout, ovf});
    end
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk); @(negedge clk);
    vectors++;
    if (busy !== 1'b0 || done !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_idle: busy=%b done=%b expected 0 0", busy, done);
    end
  endtask

  task automatic test_zero;
    int bc, lat; bit held;
    logic [W-1:0] es; logic ec, eo;
    run_op(8'h00, 8'h00, 1'b0, bc, lat, held);
    model(8'h00, 8'h00, 1'b0, es, ec, eo);
    vectors++;
    if (lat !== W || bc !== W) begin
      miscompares++;
      $display("FAIL zero_timing: lat=%0d busy=%0d expected %0d %0d", lat, bc, W, W);
    end
    vectors++;
    if ({sum, cout, ovf} !== {es, ec, eo}) begin
      miscompares++;
      $display("FAIL zero_result: got %h/%b/%b expected %h/%b/%b", sum, cout, ovf, es, ec, eo);
    end
    @(negedge clk);
    vectors++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL zero_pulse_width: done=%b busy=%b expected 0 0", done, busy);
    end
  endtask

  task automatic test_carry;
    int bc, lat; bit held;
    logic [W-1:0] es; logic ec, eo;
    run_op(8'hFF, 8'h01, 1'b0, bc, lat, held);
    model(8'hFF, 8'h01, 1'b0, es, ec, eo);
    vectors++;
    if ({sum, cout, ovf} !== {8'h00, 1'b1, 1'b0} || {sum, cout, ovf} !== {es, ec, eo}) begin
      miscompares++;
      $display("FAIL carry_ff01: got %h/%b/%b expected 00/1/0", sum, cout, ovf);
    end
    run_op(8'h80, 8'h80, 1'b0, bc, lat, held);
    model(8'h80, 8'h80, 1'b0, es, ec, eo);
    vectors++;
    if ({sum, cout, ovf} !== {8'h00, 1'b1, 1'b1} || {sum, cout, ovf} !== {es, ec, eo}) begin
      miscompares++;
      $display("FAIL carry_8080: got %h/%b/%b expected 00/1/1", sum, cout, ovf);
    end
    vectors++;
    if (!held) begin
      miscompares++;
      $display("FAIL carry_hold_during_run: got changed expected held");
    end
  endtask

  task automatic test_ovf_hold;
    int bc, lat; bit held, stable;
    logic [W-1:0] es; logic ec, eo;
    run_op(8'h7F, 8'h00, 1'b1, bc, lat, held);
    model(8'h7F, 8'h00, 1'b1, es, ec, eo);
    vectors++;
    if ({sum, cout, ovf} !== {8'h80, 1'b0, 1'b1} || {sum, cout, ovf} !== {es, ec, eo}) begin
      miscompares++;
      $display("FAIL ovf_7f00: got %h/%b/%b expected 80/0/1", sum, cout, ovf);
    end
    stable = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
      if ({sum, cout, ovf} !== {8'h80, 1'b0, 1'b1} || done !== 1'b0 || busy !== 1'b0) stable = 1'b0;
    end
    vectors++;
    if (!stable) begin
      miscompares++;
      $display("FAIL idle_hold: got sum=%h done=%b expected 80 held, no done", sum, done);
    end
  endtask

  task automatic test_back_to_back;
    int n1, gap;
    logic [W-1:0] es; logic ec, eo;
    @(negedge clk);
    a = 8'h12; b = 8'h34; cin = 1'b0; start = 1'b1;
    n1 = 0;
    do begin
      @(negedge clk); n1++;
      if (n1 == 1) begin a = W'($urandom); b = W'($urandom); cin = 1'($urandom); end
    end while (!done && n1 < 40);
    model(8'h12, 8'h34, 1'b0, es, ec, eo);
    vectors++;
    if ({sum, cout, ovf} !== {es, ec, eo} || sum !== 8'h46 || n1 !== W + 1) begin
      miscompares++;
      $display("FAIL b2b_first: got %h after %0d expected %h after %0d", sum, n1, es, W + 1);
    end
    a = 8'h0F; b = 8'hF0; cin = 1'b1;
    gap = 0;
    do begin
      @(negedge clk); gap++;
      if (gap == 1) begin a = W'($urandom); b = W'($urandom); cin = 1'($urandom); end
    end while (!done && gap < 40);
    start = 1'b0;
    model(8'h0F, 8'hF0, 1'b1, es, ec, eo);
    vectors++;
    if (gap !== W + 1) begin
      miscompares++;
      $display("FAIL b2b_gap: got %0d expected %0d", gap, W + 1);
    end
    vectors++;
    if ({sum, cout, ovf} !== {es, ec, eo} || {sum, cout} !== {8'h00, 1'b1}) begin
      miscompares++;
      $display("FAIL b2b_second: got %h/%b/%b expected %h/%b/%b", sum, cout, ovf, es, ec, eo);
    end
    @(negedge clk);
    vectors++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL b2b_release: done=%b busy=%b expected 0 0", done, busy);
    end
  endtask

  task automatic test_start_ignored;
    int pulses, first_k;
    logic [W-1:0] rs, es; logic rc, ro, ec, eo;
    logic [W-1:0] xa, xb; logic xc;
    xa = W'($urandom); xb = W'($urandom); xc = 1'($urandom);
    model(xa, xb, xc, es, ec, eo);
    @(negedge clk);
    a = xa; b = xb; cin = xc; start = 1'b1;
    pulses = 0; first_k = 0; rs = '0; rc = 1'b0; ro = 1'b0;
    for (int k = 1; k <= 30; k++) begin
      @(negedge clk);
      start = (k == 3);
      a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
      if (done) begin
        pulses++;
        if (pulses == 1) begin first_k = k; rs = sum; rc = cout; ro = ovf; end
      end
    end
    vectors++;
    if (pulses !== 1 || first_k !== W + 1) begin
      miscompares++;
      $display("FAIL ignore_start_pulses: got %0d at %0d expected 1 at %0d", pulses, first_k, W + 1);
    end
    vectors++;
    if ({rs, rc, ro} !== {es, ec, eo}) begin
      miscompares++;
      $display("FAIL ignore_start_result: got %h/%b/%b expected %h/%b/%b", rs, rc, ro, es, ec, eo);
    end
  endtask

  task automatic test_async_reset;
    int bc, lat; bit held, quiet;
    run_op(8'h7F, 8'h01, 1'b0, bc, lat, held);
    @(negedge clk);
    a = 8'hAA; b = 8'h55; cin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    vectors++;
    if ({busy, done, sum, cout, ovf} !== '0) begin
      miscompares++;
      $display("FAIL async_reset: got %h expected 0", {busy, done, sum, cout, ovf});
    end
    quiet = 1'b1;
    repeat (3) begin
      @(negedge clk);
      if (done !== 1'b0 || busy !== 1'b0) quiet = 1'b0;
    end
    rst_n = 1'b1;
    repeat (12) begin
      @(negedge clk);
      if (done !== 1'b0 || busy !== 1'b0) quiet = 1'b0;
    end
    vectors++;
    if (!quiet) begin
      miscompares++;
      $display("FAIL async_reset_idle: got activity expected no busy/done");
    end
    run_op(8'hAA, 8'h55, 1'b0, bc, lat, held);
    vectors++;
    if ({sum, cout, ovf} !== {8'hFF, 1'b0, 1'b0} || lat !== W) begin
      miscompares++;
      $display("FAIL after_reset_op: got %h/%b/%b lat %0d expected ff/0/0 lat %0d", sum, cout, ovf, lat, W);
    end
  endtask

  task automatic test_random;
    int bc, lat; bit held;
    logic [W-1:0] ra, rb, es; logic rc, ec, eo;
    for (int i = 0; i < 25; i++) begin
      ra = W'($urandom); rb = W'($urandom); rc = 1'($urandom);
      if (i == 0) begin ra = 8'h80; rb = 8'hFF; rc = 1'b0; end
      repeat ($urandom_range(0, 3)) @(negedge clk);
      run_op(ra, rb, rc, bc, lat, held);
      model(ra, rb, rc, es, ec, eo);
      vectors++;
      if ({sum, cout, ovf} !== {es, ec, eo}) begin
        miscompares++;
        $display("FAIL rand_result %0d: %h+%h+%b got %h/%b/%b expected %h/%b/%b",
                 i, ra, rb, rc, sum, cout, ovf, es, ec, eo);
      end
      vectors++;
      if (lat !== W || bc !== W || !held) begin
        miscompares++;
        $display("FAIL rand_timing %0d: lat=%0d busy=%0d held=%b expected %0d %0d 1",
                 i, lat, bc, held, W, W);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_zero();
    test_carry();
    test_ovf_hold();
    test_back_to_back();
    test_start_ignored();
    test_async_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
